// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the execute-stage branch controller: funct3 codes,
// 2-bit predictor counter encodings and the saturating counter step.
package branch_resolve_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV0 = 3'b010;
    localparam logic [2:0] F3_RSV1 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    // Saturating step: taken moves toward ST, not-taken toward SNT.
    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken && c != ST)
            r = ctr_t'(c + 2'd1);
        else if (!taken && c != SNT)
            r = ctr_t'(c - 2'd1);
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// Flop-based table of 2-bit saturating counters: one combinational read port
// (MSB = predict taken) and one synchronous update port.
module branch_bht
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    ctr_t               table_reg [ENTRIES];
    logic [ENTRIES-1:0] hit;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_hit
            assign hit[gi] = upd_en && (upd_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (!rst_n)
                table_reg[i] <= CTR_RESET;
            else if (hit[i])
                table_reg[i] <= ctr_step(table_reg[i], upd_taken);
        end
    end

    // Reads the pre-update value when read and write hit the same entry.
    assign rd_taken = table_reg[rd_idx][1];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution: condition decode, mispredict detection,
// registered redirect/flush, prediction table and debug statistics.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] f_pc,
    output logic        f_pred_taken,
    input  logic        x_valid,
    input  logic        x_is_branch,
    input  logic [2:0]  x_funct3,
    input  logic [31:0] x_pc,
    input  logic [31:0] x_target,
    input  logic        x_pred_taken,
    output logic        br_un,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
    output logic        illegal_br
);

    logic        redirect_reg;
    logic [31:0] redirect_pc_reg;
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;
    logic        illegal_br_reg;

    logic taken;
    logic f3_reserved;
    logic resolve;
    logic legal_resolve;
    logic mispredict;
    logic unused_f_pc;

    always_comb begin
        taken = 1'b0;
        case (x_funct3)
            F3_BEQ:          taken = br_eq;
            F3_BNE:          taken = !br_eq;
            F3_BLT, F3_BLTU: taken = br_lt;
            F3_BGE, F3_BGEU: taken = !br_lt;
            default:         taken = 1'b0;
        endcase
    end

    assign br_un       = (x_funct3 == F3_BLTU) || (x_funct3 == F3_BGEU);
    assign f3_reserved = (x_funct3 == F3_RSV0) || (x_funct3 == F3_RSV1);

    // The instruction in execute during a redirect cycle is wrong-path.
    assign resolve       = x_valid && x_is_branch && !stall && !redirect_reg;
    assign legal_resolve = resolve && !f3_reserved;
    assign mispredict    = legal_resolve && (taken != x_pred_taken);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_reg         <= 1'b0;
            redirect_pc_reg      <= 32'd0;
            stat_branches_reg    <= 32'd0;
            stat_mispredicts_reg <= 32'd0;
            illegal_br_reg       <= 1'b0;
        end else begin
            illegal_br_reg <= resolve && f3_reserved;
            // A stalled redirect is held until fetch can consume it.
            if (!stall) begin
                redirect_reg <= mispredict;
                if (mispredict)
                    redirect_pc_reg <= taken ? x_target : x_pc + 32'd4;
            end
            if (legal_resolve)
                stat_branches_reg <= stat_branches_reg + 32'd1;
            if (mispredict)
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
        end
    end

    branch_bht #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (f_pc[IDX_W+1:2]),
        .rd_taken  (f_pred_taken),
        .upd_en    (legal_resolve),
        .upd_idx   (x_pc[IDX_W+1:2]),
        .upd_taken (taken)
    );

    assign unused_f_pc      = ^{f_pc[31:IDX_W+2], f_pc[1:0]};
    assign redirect         = redirect_reg;
    assign flush            = redirect_reg;
    assign redirect_pc      = redirect_pc_reg;
    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
    assign illegal_br       = illegal_br_reg;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus a
// randomized run, all checked against a behavioural model of the controller.
module tb_branch_resolve_ctrl;
    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        x_valid;
    logic        x_is_branch;
    logic [2:0]  x_funct3;
    logic [31:0] x_pc;
    logic [31:0] x_target;
    logic        x_pred_taken;
    logic        br_un;
    logic        br_eq;
    logic        br_lt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    logic        illegal_br;

    int tests = 0;
    int fails = 0;

    // Behavioural model state: counters as plain integers 0..3.
    int          ctr [ENTRIES];
    logic        m_redirect;
    logic [31:0] m_rpc;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    logic        m_ill;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .x_valid          (x_valid),
        .x_is_branch      (x_is_branch),
        .x_funct3         (x_funct3),
        .x_pc             (x_pc),
        .x_target         (x_target),
        .x_pred_taken     (x_pred_taken),
        .br_un            (br_un),
        .br_eq            (br_eq),
        .br_lt            (br_lt),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
        .illegal_br       (illegal_br)
    );

    function automatic logic m_pred(input logic [31:0] pc);
        return ctr[int'(pc[31:2] % ENTRIES)] >= 2;
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        bit tk, rsv, res, mis;
        int idx;
        rsv = (x_funct3 == 3'd2) || (x_funct3 == 3'd3);
        case (x_funct3)
            3'd0: tk = br_eq;
            3'd1: tk = !br_eq;
            3'd4, 3'd6: tk = br_lt;
            3'd5, 3'd7: tk = !br_lt;
            default: tk = 1'b0;
        endcase
        res = x_valid && x_is_branch && !stall && !m_redirect;
        idx = int'(x_pc[31:2] % ENTRIES);
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] = 1;
            m_redirect = 1'b0;
            m_rpc = 32'd0;
            m_br = 32'd0;
            m_mis = 32'd0;
            m_ill = 1'b0;
        end else begin
            mis = res && !rsv && (tk != x_pred_taken);
            m_ill = res && rsv;
            if (!stall) begin
                m_redirect = mis;
                if (mis) m_rpc = tk ? x_target : x_pc + 32'd4;
            end
            if (res && !rsv) begin
                m_br = m_br + 32'd1;
                if (tk) ctr[idx] = (ctr[idx] < 3) ? ctr[idx] + 1 : 3;
                else    ctr[idx] = (ctr[idx] > 0) ? ctr[idx] - 1 : 0;
                if (mis) m_mis = m_mis + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        x_valid = 1'b0; x_is_branch = 1'b0; stall = 1'b0; x_funct3 = 3'd0;
        br_eq = 1'b0; br_lt = 1'b0; x_pred_taken = 1'b0;
        x_pc = 32'd0; x_target = 32'd0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic eq, input logic lt, input logic pred);
        x_valid = 1'b1; x_is_branch = 1'b1; x_funct3 = f3; x_pc = pc; x_target = tgt;
        br_eq = eq; br_lt = lt; x_pred_taken = pred;
    endtask

    task automatic test_reset();
        m_redirect = 1'b0;
        rst_n = 1'b0; f_pc = 32'd0; idle();
        tick(); tick();
        rst_n = 1'b1;
        tests++; if (redirect !== 1'b0) begin fails++; $display("FAIL reset_redirect got %0b want 0", redirect); end
        tests++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %0b want 0", flush); end
        tests++; if (redirect_pc !== 32'd0) begin fails++; $display("FAIL reset_redirect_pc got %h want 0", redirect_pc); end
        tests++; if (stat_branches !== 32'd0) begin fails++; $display("FAIL reset_branches got %0d want 0", stat_branches); end
        tests++; if (stat_mispredicts !== 32'd0) begin fails++; $display("FAIL reset_mispredicts got %0d want 0", stat_mispredicts); end
        tests++; if (illegal_br !== 1'b0) begin fails++; $display("FAIL reset_illegal got %0b want 0", illegal_br); end
        for (int i = 0; i < 8; i++) begin
            f_pc = $urandom; #1;
            tests++; if (f_pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred pc=%h got %0b want 0", f_pc, f_pred_taken); end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_beq_mispredict();
        branch(3'd0, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
        tick();
        tests++; if (redirect !== 1'b1 || flush !== 1'b1) begin fails++; $display("FAIL beq_redirect got %0b/%0b want 1/1", redirect, flush); end
        tests++; if (redirect_pc !== 32'h140) begin fails++; $display("FAIL beq_redirect_pc got %h want 00000140", redirect_pc); end
        tests++; if (stat_branches !== m_br || stat_mispredicts !== m_mis) begin fails++; $display("FAIL beq_stats got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_br, m_mis); end
        idle(); f_pc = 32'h100; #1;
        tests++; if (f_pred_taken !== m_pred(32'h100)) begin fails++; $display("FAIL beq_pred got %0b want %0b", f_pred_taken, m_pred(32'h100)); end
        tick();
        tests++; if (redirect !== 1'b0) begin fails++; $display("FAIL beq_redirect_drop got %0b want 0", redirect); end
        $display("[TB] test_beq_mispredict done");
    endtask

    task automatic test_bne_saturate();
        branch(3'd1, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0);
        tick();
        tests++; if (redirect !== m_redirect) begin fails++; $display("FAIL bne_redirect got %0b want %0b", redirect, m_redirect); end
        tick();
        tests++; if (stat_branches !== m_br || stat_mispredicts !== m_mis) begin fails++; $display("FAIL bne_stats got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_br, m_mis); end
        // A taken resolve from a saturated 00 must give 01, still predicting not-taken.
        branch(3'd0, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0);
        tick();
        idle(); f_pc = 32'h200; #1;
        tests++; if (f_pred_taken !== m_pred(32'h200)) begin fails++; $display("FAIL bne_saturate_pred got %0b want %0b", f_pred_taken, m_pred(32'h200)); end
        tick();
        $display("[TB] test_bne_saturate done");
    endtask

    task automatic test_unsigned_select();
        logic [2:0] f3;
        for (int i = 0; i < 8; i++) begin
            f3 = 3'(i);
            x_funct3 = f3; x_valid = 1'($urandom_range(0, 1)); x_pc = 32'h300; #1;
            tests++; if (br_un !== ((f3 == 3'd6) || (f3 == 3'd7))) begin fails++; $display("FAIL br_un f3=%0d got %0b", f3, br_un); end
        end
        branch(3'd5, 32'h300, 32'h380, 1'b0, 1'b0, 1'b1);
        tick();
        tests++; if (redirect !== m_redirect) begin fails++; $display("FAIL bge_nomis got %0b want %0b", redirect, m_redirect); end
        branch(3'd5, 32'h300, 32'h380, 1'b0, 1'b1, 1'b1);
        tick();
        tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h304) begin fails++; $display("FAIL bge_mis got %0b/%h want 1/00000304", redirect, redirect_pc); end
        idle(); tick();
        $display("[TB] test_unsigned_select done");
    endtask

    task automatic test_stall_hold();
        int held;
        logic [31:0] br_before;
        branch(3'd4, 32'h400, 32'h480, 1'b0, 1'b1, 1'b0);
        tick();
        br_before = m_br;
        // Keep a wrong-path branch in execute through the whole redirect window.
        branch(3'd0, 32'h404, 32'h500, 1'b0, 1'b0, 1'b1);
        held = 0;
        for (int c = 0; c < 10 && redirect === 1'b1; c++) begin
            held++;
            stall = (held <= 2);
            tests++; if (redirect_pc !== 32'h480) begin fails++; $display("FAIL stall_redirect_pc got %h want 00000480", redirect_pc); end
            tick();
        end
        tests++; if (held != 3) begin fails++; $display("FAIL stall_hold cycles got %0d want 3", held); end
        tests++; if (stat_branches !== br_before) begin fails++; $display("FAIL shadow_stats got %0d want %0d", stat_branches, br_before); end
        idle(); f_pc = 32'h404; #1;
        tests++; if (f_pred_taken !== m_pred(32'h404)) begin fails++; $display("FAIL shadow_table got %0b want %0b", f_pred_taken, m_pred(32'h404)); end
        $display("[TB] test_stall_hold done");
    endtask

    task automatic test_illegal_rbw();
        logic old_p, new_p;
        branch(3'd2, 32'h600, 32'h640, 1'b1, 1'b1, 1'b0);
        tick();
        tests++; if (illegal_br !== 1'b1 || redirect !== 1'b0) begin fails++; $display("FAIL illegal_pulse got %0b/%0b want 1/0", illegal_br, redirect); end
        tests++; if (stat_branches !== m_br || stat_mispredicts !== m_mis) begin fails++; $display("FAIL illegal_stats got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_br, m_mis); end
        idle(); tick();
        tests++; if (illegal_br !== 1'b0) begin fails++; $display("FAIL illegal_drop got %0b want 0", illegal_br); end
        // Same entry on read and write: old value this cycle, new value next.
        branch(3'd0, 32'h100, 32'h140, 1'b1, 1'b0, 1'b1);
        f_pc = 32'h100; #1;
        old_p = m_pred(32'h100);
        tests++; if (f_pred_taken !== old_p) begin fails++; $display("FAIL rbw_old got %0b want %0b", f_pred_taken, old_p); end
        tick();
        new_p = m_pred(32'h100);
        idle(); #1;
        tests++; if (f_pred_taken !== new_p) begin fails++; $display("FAIL rbw_new got %0b want %0b", f_pred_taken, new_p); end
        tick();
        $display("[TB] test_illegal_rbw done");
    endtask

    task automatic test_wrap_reset();
        force dut.stat_mispredicts_reg = 32'hFFFF_FFFF;
        #1;
        release dut.stat_mispredicts_reg;
        m_mis = 32'hFFFF_FFFF;
        branch(3'd1, 32'h700, 32'h740, 1'b0, 1'b0, 1'b0);
        tick();
        tests++; if (stat_mispredicts !== 32'd0 || stat_mispredicts !== m_mis) begin fails++; $display("FAIL mis_wrap got %h want 00000000", stat_mispredicts); end
        tests++; if (redirect !== 1'b1) begin fails++; $display("FAIL wrap_redirect got %0b want 1", redirect); end
        idle(); rst_n = 1'b0;
        tick();
        tests++; if (redirect !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL reset_cancel got %0b/%0b want 0/0", redirect, flush); end
        rst_n = 1'b1;
        $display("[TB] test_wrap_reset done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            x_valid      = ($urandom_range(0, 3) != 0);
            x_is_branch  = ($urandom_range(0, 4) != 0);
            x_funct3     = 3'($urandom_range(0, 7));
            x_pc         = {$urandom_range(0, 255), 2'b00};
            x_target     = $urandom;
            br_eq        = 1'($urandom_range(0, 1));
            br_lt        = 1'($urandom_range(0, 1));
            x_pred_taken = 1'($urandom_range(0, 1));
            stall        = ($urandom_range(0, 7) == 0);
            f_pc         = ($urandom_range(0, 1) != 0) ? x_pc : {$urandom_range(0, 255), 2'b00};
            #1;
            tests++; if (f_pred_taken !== m_pred(f_pc)) begin fails++; $display("FAIL rnd_pred n=%0d pc=%h got %0b want %0b", n, f_pc, f_pred_taken, m_pred(f_pc)); end
            tick();
            tests++; if (redirect !== m_redirect || flush !== m_redirect) begin fails++; $display("FAIL rnd_redirect n=%0d got %0b/%0b want %0b", n, redirect, flush, m_redirect); end
            if (m_redirect) begin
                tests++; if (redirect_pc !== m_rpc) begin fails++; $display("FAIL rnd_redirect_pc n=%0d got %h want %h", n, redirect_pc, m_rpc); end
            end
            tests++; if (stat_branches !== m_br || stat_mispredicts !== m_mis) begin fails++; $display("FAIL rnd_stats n=%0d got %0d/%0d want %0d/%0d", n, stat_branches, stat_mispredicts, m_br, m_mis); end
            tests++; if (illegal_br !== m_ill) begin fails++; $display("FAIL rnd_illegal n=%0d got %0b want %0b", n, illegal_br, m_ill); end
        end
        idle();
        $display("[TB] test_random done");
    endtask

    initial begin
        test_reset();
        test_beq_mispredict();
        test_bne_saturate();
        test_unsigned_select();
        test_stall_hold();
        test_illegal_rbw();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
